// File: rtl/eth_hdr_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eth_hdr_writer_pkg
//  Description : Shared constants and types for the Ethernet header writer.
//                Ethernet header field offsets (bit positions in beat 0),
//                EtherType values in on-wire little-endian byte order, and
//                the writer's state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package eth_hdr_writer_pkg;

    // Bit offsets of the Ethernet header fields inside the first beat
    localparam int ETH_DST_LO  = 0;
    localparam int ETH_SRC_LO  = 48;
    localparam int ETH_TYPE_LO = 96;
    localparam int ETH_MAC_W   = 48;

    // EtherType values as they appear in tdata (bytes swapped)
    localparam logic [15:0] ETH_ARP = 16'h0608;
    localparam logic [15:0] ETH_IP  = 16'h0008;

    // Header-info record layout: {drop, out_port, next_hop_mac}
    localparam int HDR_MAC_LO = 0;

    typedef enum logic [0:0] {
        ST_WORD0 = 1'b0,    // waiting for / holding the first beat
        ST_BODY  = 1'b1     // remaining beats of the packet
    } wr_state_e;

endpackage
`default_nettype wire

// File: rtl/eth_hdr_writer_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fallthrough_small_fifo
//  Description : Small first-word-fall-through FIFO. dout always shows the
//                head entry while empty is low; rd_en pops it. A write while
//                full is accepted only if a read happens in the same cycle.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                din, wr_en      - write data / push strobe
//                rd_en           - pop strobe (ignored when empty)
//                dout            - head entry
//                full, empty     - occupancy flags
//                nearly_full     - one slot or fewer left
//  Revision    : 1.0 - initial release
// ============================================================================
module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             nearly_full,
    output logic             empty
);
    localparam int DEPTH = 1 << MAX_DEPTH_BITS;
    localparam int CNT_W = MAX_DEPTH_BITS + 1;

    logic [WIDTH-1:0]          mem_q [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]          count_q;
    logic                      w_do_rd, w_do_wr;

    assign empty       = (count_q == '0);
    assign full        = (count_q == CNT_W'(DEPTH));
    assign nearly_full = (count_q >= CNT_W'(DEPTH - 1));
    assign dout        = mem_q[rd_ptr_q];

    // A pop in the same cycle frees a slot for a push on a full FIFO
    assign w_do_rd = rd_en & ~empty;
    assign w_do_wr = wr_en & (~full | w_do_rd);

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({w_do_wr, w_do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/eth_hdr_writer.sv
`default_nettype none
// ============================================================================
//  Module      : eth_hdr_writer
//  Description : Transmit-side Ethernet header writer. Pairs each packet with
//                a queued header-info record, rewrites the destination MAC
//                (next hop) and source MAC (output-port MAC) in the first
//                beat, and forwards the packet, or discards it when the
//                record's drop flag is set.
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                s_axis_*              - input packet stream
//                m_axis_*              - rewritten packet stream
//                hdr_*                 - header-info record push interface
//                hdr_info_nearly_full  - info FIFO holds 3 or more records
//                mac_0 .. mac_3        - per-port source MAC addresses
//                pkt_fwd_cnt/drop_cnt  - forwarded / dropped packet counters
//                info_overflow         - sticky push-while-full flag
//  Revision    : 1.0 - initial release
// ============================================================================
module eth_hdr_writer
    import eth_hdr_writer_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH = 256,
    parameter int NUM_QUEUES          = 8,
    parameter int NUM_QUEUES_WIDTH    = $clog2(NUM_QUEUES)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                             s_axis_tvalid,
    input  logic                             s_axis_tlast,
    output logic                             s_axis_tready,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                             m_axis_tvalid,
    output logic                             m_axis_tlast,
    input  logic                             m_axis_tready,
    input  logic                             hdr_info_wr_en,
    input  logic [47:0]                      hdr_next_hop_mac,
    input  logic [NUM_QUEUES_WIDTH-1:0]      hdr_out_port,
    input  logic                             hdr_drop,
    output logic                             hdr_info_nearly_full,
    input  logic [47:0]                      mac_0,
    input  logic [47:0]                      mac_1,
    input  logic [47:0]                      mac_2,
    input  logic [47:0]                      mac_3,
    output logic [31:0]                      pkt_fwd_cnt,
    output logic [31:0]                      pkt_drop_cnt,
    output logic                             info_overflow
);
    localparam int INFO_W = 49 + NUM_QUEUES_WIDTH;

    logic [INFO_W-1:0]           info_din, info_head;
    logic                        info_empty, info_full, info_vld;
    logic                        head_drop;
    logic [NUM_QUEUES_WIDTH-1:0] head_port;
    logic [47:0]                 head_mac;
    logic [47:0]                 mac_sel;
    logic                        xfer, pop;

    wr_state_e   state_q, state_d;
    logic [31:0] fwd_q, fwd_d, drop_q, drop_d;
    logic        ovf_q, ovf_d;

    assign info_din = {hdr_drop, hdr_out_port, hdr_next_hop_mac};

    fallthrough_small_fifo #(
        .WIDTH          (INFO_W),
        .MAX_DEPTH_BITS (2)
    ) u_info_fifo (
        .clk         (clk),
        .reset       (reset),
        .din         (info_din),
        .wr_en       (hdr_info_wr_en),
        .rd_en       (pop),
        .dout        (info_head),
        .full        (info_full),
        .nearly_full (hdr_info_nearly_full),
        .empty       (info_empty)
    );

    assign info_vld  = ~info_empty;
    assign head_mac  = info_head[HDR_MAC_LO +: ETH_MAC_W];
    assign head_port = info_head[ETH_MAC_W +: NUM_QUEUES_WIDTH];
    assign head_drop = info_head[INFO_W-1];

    // Dropped packets are sunk regardless of downstream ready
    assign s_axis_tready = info_vld & (head_drop | m_axis_tready);
    assign m_axis_tvalid = s_axis_tvalid & info_vld & ~head_drop;
    assign m_axis_tkeep  = s_axis_tkeep;
    assign m_axis_tlast  = s_axis_tlast;

    assign xfer = s_axis_tvalid & s_axis_tready;
    assign pop  = xfer & s_axis_tlast;

    // MAC ports sit on even queues, so the port MAC index drops bit 0
    always_comb begin
        mac_sel = '0;
        case (32'(head_port[NUM_QUEUES_WIDTH-1:1]))
            32'd0:   mac_sel = mac_0;
            32'd1:   mac_sel = mac_1;
            32'd2:   mac_sel = mac_2;
            32'd3:   mac_sel = mac_3;
            default: mac_sel = '0;
        endcase
    end

    always_comb begin
        m_axis_tdata = s_axis_tdata;
        if (state_q == ST_WORD0) begin
            m_axis_tdata[ETH_DST_LO +: ETH_MAC_W] = head_mac;
            m_axis_tdata[ETH_SRC_LO +: ETH_MAC_W] = mac_sel;
        end
    end

    always_comb begin
        state_d = state_q;
        fwd_d   = fwd_q;
        drop_d  = drop_q;
        ovf_d   = ovf_q;
        if (xfer) begin
            state_d = s_axis_tlast ? ST_WORD0 : ST_BODY;
        end
        if (pop) begin
            if (head_drop) drop_d = drop_q + 32'd1;
            else           fwd_d  = fwd_q + 32'd1;
        end
        // A simultaneous pop makes room, so only a pop-less push overflows
        if (hdr_info_wr_en & info_full & ~pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_WORD0;
            fwd_q   <= '0;
            drop_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fwd_q   <= fwd_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
        end
    end

    assign pkt_fwd_cnt   = fwd_q;
    assign pkt_drop_cnt  = drop_q;
    assign info_overflow = ovf_q;

`ifndef SYNTHESIS
    // Warn when a packet has been waiting on a missing header record too long
    logic [10:0] starve_cnt_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else if ((state_q == ST_WORD0) && s_axis_tvalid && !info_vld) begin
            if (starve_cnt_q == 11'd1024) begin
                $display("eth_hdr_writer warning: packet waiting >1024 cycles for header info");
            end else begin
                starve_cnt_q <= starve_cnt_q + 11'd1;
            end
        end else begin
            starve_cnt_q <= '0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_eth_hdr_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eth_hdr_writer
//  Description : Self-checking bench for eth_hdr_writer. Expected output
//                beats are queued when stimulus is driven and compared when
//                the DUT presents them; single-beat cases come from a table.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_hdr_writer;

    localparam logic [47:0] MAC0 = 48'h0A0000000000;
    localparam logic [47:0] MAC1 = 48'hAABBCCDDEEFF;
    localparam logic [47:0] MAC2 = 48'h0C1122334455;
    localparam logic [47:0] MAC3 = 48'h0D6677889900;

    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] s_axis_tdata;
    logic [31:0]  s_axis_tkeep;
    logic         s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tkeep;
    logic         m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic         hdr_info_wr_en, hdr_drop, hdr_info_nearly_full;
    logic [47:0]  hdr_next_hop_mac;
    logic [2:0]   hdr_out_port;
    logic [31:0]  pkt_fwd_cnt, pkt_drop_cnt;
    logic         info_overflow;

    eth_hdr_writer dut (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .hdr_info_wr_en(hdr_info_wr_en), .hdr_next_hop_mac(hdr_next_hop_mac),
        .hdr_out_port(hdr_out_port), .hdr_drop(hdr_drop),
        .hdr_info_nearly_full(hdr_info_nearly_full),
        .mac_0(MAC0), .mac_1(MAC1), .mac_2(MAC2), .mac_3(MAC3),
        .pkt_fwd_cnt(pkt_fwd_cnt), .pkt_drop_cnt(pkt_drop_cnt),
        .info_overflow(info_overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [255:0] d;
        logic [31:0]  k;
        logic         l;
    } beat_t;

    typedef struct {
        logic         drop;
        logic [2:0]   port;
        logic [47:0]  nh;
        logic [255:0] data;
        logic [31:0]  keep;
        logic         exp_out;
        logic [255:0] exp_data;
    } vec_t;

    beat_t       exp_q[$];
    vec_t        tbl[6];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_fwd, exp_drop;
    logic [47:0] nh_list[5];
    logic [2:0]  port_list[5];

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [47:0] port_mac(input logic [2:0] port);
        case (port[2:1])
            2'd0:    return MAC0;
            2'd1:    return MAC1;
            2'd2:    return MAC2;
            default: return MAC3;
        endcase
    endfunction

    function automatic logic [255:0] rewrite(input logic [255:0] d,
                                             input logic [2:0] port,
                                             input logic [47:0] nh);
        logic [255:0] r;
        r        = d;
        r[47:0]  = nh;
        r[95:48] = port_mac(port);
        return r;
    endfunction

    function automatic logic [255:0] rand256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Output monitor: compares every beat the DUT hands downstream
    always @(negedge clk) begin
        if (!reset && m_axis_tvalid && m_axis_tready) begin
            beat_t act, exp;
            act = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_beat: got data %h with nothing expected", m_axis_tdata);
            end else begin
                exp = exp_q.pop_front();
                n_checks++;
                if (act == exp) n_pass++;
                else $display("FAIL out_beat: got %h/%h/%b expected %h/%h/%b",
                              act.d, act.k, act.l, exp.d, exp.k, exp.l);
            end
        end
    end

    task automatic do_reset();
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        s_axis_tdata = '0; s_axis_tkeep = '0;
        hdr_info_wr_en = 1'b0; hdr_drop = 1'b0;
        hdr_out_port = '0; hdr_next_hop_mac = '0;
        m_axis_tready = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_fwd = '0; exp_drop = '0;
    endtask

    task automatic push_info(input logic drop, input logic [2:0] port, input logic [47:0] nh);
        hdr_drop = drop; hdr_out_port = port; hdr_next_hop_mac = nh;
        hdr_info_wr_en = 1'b1;
        @(posedge clk); #1;
        hdr_info_wr_en = 1'b0;
    endtask

    task automatic send_beat(input logic [255:0] d, input logic [31:0] k,
                             input logic l, input logic is_drop);
        int waited;
        waited = 0;
        s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_axis_tready) break;
            waited++;
            if (waited >= 200) begin
                check(1'b0, "beat_timeout", 64'(waited), 64'd0);
                s_axis_tvalid = 1'b0;
                return;
            end
        end
        if (is_drop) begin
            check(m_axis_tvalid == 1'b0, "drop_tvalid", 64'(m_axis_tvalid), 64'd0);
            check(waited == 0, "drop_ready_wait", 64'(waited), 64'd0);
        end
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_packet(input logic drop, input logic [2:0] port,
                               input logic [47:0] nh, input int nbeats);
        logic [255:0] d;
        logic [31:0]  k;
        for (int b = 0; b < nbeats; b++) begin
            d = rand256();
            k = $urandom();
            if (!drop) exp_q.push_back({(b == 0) ? rewrite(d, port, nh) : d, k, (b == nbeats - 1)});
            send_beat(d, k, (b == nbeats - 1), drop);
        end
        if (drop) exp_drop++;
        else      exp_fwd++;
    endtask

    task automatic check_counts(input string tag);
        check(pkt_fwd_cnt == exp_fwd, {tag, "_fwd_cnt"}, 64'(pkt_fwd_cnt), 64'(exp_fwd));
        check(pkt_drop_cnt == exp_drop, {tag, "_drop_cnt"}, 64'(pkt_drop_cnt), 64'(exp_drop));
    endtask

    initial begin
        logic [255:0] d;
        logic [31:0]  k;

        // Single-beat vectors; expected first beat written out by hand
        for (int i = 0; i < 6; i++) begin
            tbl[i].data = rand256();
            tbl[i].keep = $urandom();
            tbl[i].nh   = {16'h5A00 + 16'(i), 32'hC0DE0000 + 32'(i)};
            tbl[i].drop = 1'b0;
            tbl[i].exp_out = 1'b1;
        end
        tbl[0].port = 3'd0; tbl[0].exp_data = {tbl[0].data[255:96], MAC0, tbl[0].nh};
        tbl[1].port = 3'd2; tbl[1].exp_data = {tbl[1].data[255:96], MAC1, tbl[1].nh};
        tbl[2].port = 3'd4; tbl[2].exp_data = {tbl[2].data[255:96], MAC2, tbl[2].nh};
        tbl[3].port = 3'd6; tbl[3].exp_data = {tbl[3].data[255:96], MAC3, tbl[3].nh};
        tbl[4].port = 3'd1; tbl[4].drop = 1'b1; tbl[4].exp_out = 1'b0;
        tbl[4].exp_data = '0;
        tbl[5].port = 3'd7; tbl[5].exp_data = {tbl[5].data[255:96], MAC3, tbl[5].nh};

        // Reset state
        do_reset();
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        check(s_axis_tready == 1'b0, "rst_s_tready", 64'(s_axis_tready), 64'd0);
        check(m_axis_tvalid == 1'b0, "rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check(info_overflow == 1'b0, "rst_overflow", 64'(info_overflow), 64'd0);
        check(hdr_info_nearly_full == 1'b0, "rst_nearly_full", 64'(hdr_info_nearly_full), 64'd0);
        check_counts("rst");
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;

        // 1: rewrite on a 3-beat packet
        push_info(1'b0, 3'd2, 48'h112233445566);
        send_packet(1'b0, 3'd2, 48'h112233445566, 3);
        check_counts("t1");

        // 2: dropped 2-beat packet
        push_info(1'b1, 3'd4, 48'hDEADBEEF0001);
        send_packet(1'b1, 3'd4, 48'hDEADBEEF0001, 2);
        check_counts("t2");

        // 3: info starvation, then record arrives
        d = rand256();
        k = $urandom();
        exp_q.push_back({rewrite(d, 3'd4, 48'h0102030405AA), k, 1'b1});
        s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check(s_axis_tready == 1'b0, "starve_ready", 64'(s_axis_tready), 64'd0);
            @(posedge clk); #1;
        end
        push_info(1'b0, 3'd4, 48'h0102030405AA);
        @(negedge clk);
        check(s_axis_tready == 1'b1, "starve_ready_after_push", 64'(s_axis_tready), 64'd1);
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        exp_fwd++;
        check_counts("t3");

        // 4: backpressure on a 4-beat packet
        push_info(1'b0, 3'd6, 48'hFEDCBA987654);
        fork
            begin
                for (int c = 0; c < 16; c++) begin
                    m_axis_tready = (c % 2 == 0);
                    @(posedge clk); #1;
                end
                m_axis_tready = 1'b1;
            end
            send_packet(1'b0, 3'd6, 48'hFEDCBA987654, 4);
        join
        check_counts("t4");

        // 5: four queued records, back-to-back single-beat packets
        for (int i = 0; i < 4; i++) push_info(tbl[i].drop, tbl[i].port, tbl[i].nh);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({tbl[i].exp_data, tbl[i].keep, 1'b1});
            send_beat(tbl[i].data, tbl[i].keep, 1'b1, 1'b0);
            exp_fwd++;
        end
        for (int i = 4; i < 6; i++) begin
            push_info(tbl[i].drop, tbl[i].port, tbl[i].nh);
            if (tbl[i].exp_out) exp_q.push_back({tbl[i].exp_data, tbl[i].keep, 1'b1});
            send_beat(tbl[i].data, tbl[i].keep, 1'b1, tbl[i].drop);
            if (tbl[i].drop) exp_drop++;
            else             exp_fwd++;
        end
        check_counts("t5");

        // 6: overflow with five pushes, first four records kept
        do_reset();
        for (int i = 0; i < 5; i++) begin
            nh_list[i]   = {16'hB000 + 16'(i), 32'h12340000 + 32'(i)};
            port_list[i] = 3'(2 * (i % 4));
            push_info(1'b0, port_list[i], nh_list[i]);
            if (i == 1) check(hdr_info_nearly_full == 1'b0, "nf_after_2", 64'(hdr_info_nearly_full), 64'd0);
            if (i == 2) check(hdr_info_nearly_full == 1'b1, "nf_after_3", 64'(hdr_info_nearly_full), 64'd1);
            if (i == 3) check(info_overflow == 1'b0, "ovf_after_4", 64'(info_overflow), 64'd0);
            if (i == 4) check(info_overflow == 1'b1, "ovf_after_5", 64'(info_overflow), 64'd1);
        end
        for (int i = 0; i < 4; i++) send_packet(1'b0, port_list[i], nh_list[i], 1);
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        check(s_axis_tready == 1'b0, "drained_empty", 64'(s_axis_tready), 64'd0);
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        check_counts("t6");

        // 7: push and pop in the same cycle on a full FIFO
        do_reset();
        for (int i = 0; i < 4; i++) push_info(1'b0, port_list[i], nh_list[i]);
        hdr_drop = 1'b0; hdr_out_port = 3'd3; hdr_next_hop_mac = 48'h777777777777;
        hdr_info_wr_en = 1'b1;
        send_packet(1'b0, port_list[0], nh_list[0], 1);
        hdr_info_wr_en = 1'b0;
        check(info_overflow == 1'b0, "ovf_push_pop", 64'(info_overflow), 64'd0);
        for (int i = 1; i < 4; i++) send_packet(1'b0, port_list[i], nh_list[i], 1);
        send_packet(1'b0, 3'd3, 48'h777777777777, 1);
        check_counts("t7");

        repeat (3) @(posedge clk);
        check(exp_q.size() == 0, "scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
